// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration, IDLE/SETUP/ACCESS
// sequencing, read data and error return, and a wait-state timeout.
//
// Ports:
//   pclk, preset            clock, synchronous active-high reset
//   reqX_valid/write/addr/wdata   command from requester X (0/1)
//   reqX_ack                pulse: command accepted, payload captured
//   reqX_done/rdata/err     pulse: transfer finished, with result
//   psel/penable/paddr/pwrite/pwdata   APB request side (registered)
//   prdata/pready/pslverr   APB response side
//   busy                    high during SETUP and ACCESS
module apb_master_arbiter #(
   parameter int N          = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic                  req0_valid,
   input  logic                  req0_write,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [N-1:0]          req0_wdata,
   output logic                  req0_ack,
   output logic                  req0_done,
   output logic [N-1:0]          req0_rdata,
   output logic                  req0_err,
   input  logic                  req1_valid,
   input  logic                  req1_write,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [N-1:0]          req1_wdata,
   output logic                  req1_ack,
   output logic                  req1_done,
   output logic [N-1:0]          req1_rdata,
   output logic                  req1_err,
   output logic                  psel,
   output logic                  penable,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  pwrite,
   output logic [N-1:0]          pwdata,
   input  logic [N-1:0]          prdata,
   input  logic                  pready,
   input  logic                  pslverr,
   output logic                  busy
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST =
      (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

   state_e                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  last_q, last_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  busy_q, busy_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [N-1:0]          pwdata_q, pwdata_d;
   logic                  ack0_q, ack0_d, ack1_q, ack1_d;
   logic                  done0_q, done0_d, done1_q, done1_d;
   logic                  err0_q, err0_d, err1_q, err1_d;
   logic [N-1:0]          rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   logic                  any_req, win1, tmo, fin, fin_err;
   logic [N-1:0]          fin_rdata;

   assign any_req = req0_valid | req1_valid;
   // last_q == 1 means port 1 won last time, so port 0 wins a tie.
   assign win1 = req1_valid & (~req0_valid | ~last_q);
   // Counter holds completed wait cycles; the ACCESS cycle that would
   // be number TIMEOUT ends the transfer unless pready arrives.
   assign tmo = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
   assign fin = (state_q == S_ACCESS) && (pready || tmo);
   // pready wins over a coincident timeout.
   assign fin_err   = pready ? pslverr : 1'b1;
   assign fin_rdata = (pready && !pwrite_q) ? prdata : '0;

   always_ff @(posedge pclk) begin
      if (preset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (any_req) state_d = S_SETUP;
         S_SETUP:  state_d = S_ACCESS;
         S_ACCESS: if (fin) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      owner_d   = owner_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      busy_d    = busy_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      done0_d   = 1'b0;
      done1_d   = 1'b0;
      err0_d    = 1'b0;
      err1_d    = 1'b0;
      rdata0_d  = '0;
      rdata1_d  = '0;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               owner_d   = win1;
               last_d    = win1;
               paddr_d   = win1 ? req1_addr  : req0_addr;
               pwrite_d  = win1 ? req1_write : req0_write;
               pwdata_d  = win1 ? req1_wdata : req0_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               busy_d    = 1'b1;
               ack0_d    = ~win1;
               ack1_d    = win1;
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
         end
         S_ACCESS: begin
            if (fin) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               busy_d    = 1'b0;
               done0_d   = ~owner_q;
               done1_d   = owner_q;
               err0_d    = ~owner_q & fin_err;
               err1_d    = owner_q & fin_err;
               rdata0_d  = owner_q ? '0 : fin_rdata;
               rdata1_d  = owner_q ? fin_rdata : '0;
            end else if (cnt_q != {CW{1'b1}}) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         busy_q    <= 1'b0;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         owner_q   <= owner_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         busy_q    <= busy_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign psel       = psel_q;
   assign penable    = penable_q;
   assign busy       = busy_q;
   assign paddr      = paddr_q;
   assign pwrite     = pwrite_q;
   assign pwdata     = pwdata_q;
   assign req0_ack   = ack0_q;
   assign req1_ack   = ack1_q;
   assign req0_done  = done0_q;
   assign req1_done  = done1_q;
   assign req0_err   = err0_q;
   assign req1_err   = err1_q;
   assign req0_rdata = rdata0_q;
   assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: requester drivers, APB slave
// model, and per-cycle bus/completion checks against queued expectations.
module tb_apb_master_arbiter;

   localparam int N  = 16;
   localparam int AW = 32;
   localparam int TO = 16;

   logic          pclk = 1'b0;
   logic          preset = 1'b1;
   logic          req0_valid = 1'b0, req0_write = 1'b0;
   logic [AW-1:0] req0_addr = '0;
   logic [N-1:0]  req0_wdata = '0;
   logic          req1_valid = 1'b0, req1_write = 1'b0;
   logic [AW-1:0] req1_addr = '0;
   logic [N-1:0]  req1_wdata = '0;
   logic          req0_ack, req0_done, req0_err;
   logic          req1_ack, req1_done, req1_err;
   logic [N-1:0]  req0_rdata, req1_rdata;
   logic          psel, penable, pwrite, busy;
   logic [AW-1:0] paddr;
   logic [N-1:0]  pwdata;
   logic [N-1:0]  prdata = '0;
   logic          pready = 1'b0, pslverr = 1'b0;

   apb_master_arbiter #(.N(N), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .pclk(pclk), .preset(preset),
      .req0_valid(req0_valid), .req0_write(req0_write),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_ack(req0_ack), .req0_done(req0_done),
      .req0_rdata(req0_rdata), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_write(req1_write),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_ack(req1_ack), .req1_done(req1_done),
      .req1_rdata(req1_rdata), .req1_err(req1_err),
      .psel(psel), .penable(penable), .paddr(paddr),
      .pwrite(pwrite), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .busy(busy)
   );

   initial forever #5 pclk = ~pclk;

   typedef struct {
      logic          port;
      logic          wr;
      logic [AW-1:0] addr;
      logic [N-1:0]  wd;
      int            waits;
      logic [N-1:0]  rd;
      logic          slv;
   } txn_t;

   typedef struct {
      logic         port;
      logic [N-1:0] rdata;
      logic         err;
      int           acc;
   } done_t;

   txn_t  q_cmd0[$], q_cmd1[$], q_bus[$];
   done_t q_done[$];
   txn_t  cur, d0, d1;
   done_t dexp;

   int n_vec = 0, n_err = 0;
   int cyc = 0, acc = 0;
   int tv0 = 0, tv1 = 0, t_setup = 0, t_done = 0, t_mark = 0;
   bit mark = 0, prev_psel = 0, got0 = 0, got1 = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic txn_t mk(input logic port, input logic wr,
                               input logic [AW-1:0] a,
                               input logic [N-1:0] wd, input int waits,
                               input logic [N-1:0] rd, input logic slv);
      txn_t t;
      t.port = port; t.wr = wr; t.addr = a; t.wd = wd;
      t.waits = waits; t.rd = rd; t.slv = slv;
      return t;
   endfunction

   // waits < 0: slave never answers.
   task automatic post(input txn_t t, input bit exp_done);
      done_t d;
      bit    to;
      if (t.port) q_cmd1.push_back(t);
      else        q_cmd0.push_back(t);
      q_bus.push_back(t);
      if (exp_done) begin
         to      = (t.waits < 0) || (t.waits >= TO);
         d.port  = t.port;
         d.err   = to ? 1'b1 : t.slv;
         d.rdata = (to || t.wr) ? '0 : t.rd;
         d.acc   = to ? TO : t.waits + 1;
         q_done.push_back(d);
      end
   endtask

   task automatic drain(input string tag);
      int i;
      i = 0;
      while ((q_bus.size() != 0 || q_done.size() != 0 ||
              q_cmd0.size() != 0 || q_cmd1.size() != 0 ||
              req0_valid || req1_valid) && i < 300) begin
         @(negedge pclk); #1;
         i++;
      end
      chk({tag, "_timeout"}, (i >= 300), 0);
      repeat (2) @(negedge pclk);
      #1;
   endtask

   initial forever begin
      @(posedge pclk);
      cyc++;
   end

   initial forever begin
      @(posedge pclk); #1;
      if (req0_valid && got0) begin
         req0_valid = 1'b0;
         got0 = 1'b0;
      end
      if (!req0_valid && q_cmd0.size() != 0) begin
         d0 = q_cmd0.pop_front();
         req0_write = d0.wr;
         req0_addr  = d0.addr;
         req0_wdata = d0.wd;
         req0_valid = 1'b1;
         tv0 = cyc;
      end
   end

   initial forever begin
      @(posedge pclk); #1;
      if (req1_valid && got1) begin
         req1_valid = 1'b0;
         got1 = 1'b0;
      end
      if (!req1_valid && q_cmd1.size() != 0) begin
         d1 = q_cmd1.pop_front();
         req1_write = d1.wr;
         req1_addr  = d1.addr;
         req1_wdata = d1.wd;
         req1_valid = 1'b1;
         tv1 = cyc;
      end
   end

   // Monitor, scoreboard and APB slave model.
   initial forever begin
      @(negedge pclk);
      if (req0_valid && req0_ack) got0 = 1'b1;
      if (req1_valid && req1_ack) got1 = 1'b1;
      chk("busy", busy, psel);
      if (psel && !penable) begin
         chk("gap", prev_psel, 0);
         if (q_bus.size() == 0) begin
            chk("bus_unexpected", 1, 0);
         end else begin
            cur = q_bus.pop_front();
            chk("setup_addr", paddr, cur.addr);
            chk("setup_wr", pwrite, cur.wr);
            chk("setup_wdata", pwdata, cur.wd);
            chk("ack", {req1_ack, req0_ack},
                cur.port ? 2'b10 : 2'b01);
         end
         acc = 0;
         t_setup = cyc;
         if (mark) begin
            t_mark = cyc;
            mark = 1'b0;
         end
      end else begin
         chk("ack_stray", {req1_ack, req0_ack}, 0);
      end
      if (psel && penable) begin
         acc++;
         chk("acc_addr", paddr, cur.addr);
         chk("acc_wr", pwrite, cur.wr);
         chk("acc_wdata", pwdata, cur.wd);
         pready  = (cur.waits >= 0) && (acc - 1 == cur.waits);
         prdata  = cur.rd;
         pslverr = cur.slv;
      end else begin
         pready  = 1'b0;
         pslverr = 1'b0;
         prdata  = 16'hA5A5;
      end
      if (req0_done || req1_done) begin
         chk("done_bus", {psel, penable}, 0);
         if (q_done.size() == 0) begin
            chk("done_unexpected", 1, 0);
         end else begin
            dexp = q_done.pop_front();
            chk("done_port", {req1_done, req0_done},
                dexp.port ? 2'b10 : 2'b01);
            chk("rdata", dexp.port ? req1_rdata : req0_rdata,
                dexp.rdata);
            chk("rdata_other", dexp.port ? req0_rdata : req1_rdata, 0);
            chk("err", dexp.port ? req1_err : req0_err, dexp.err);
            chk("err_other", dexp.port ? req0_err : req1_err, 0);
            chk("acc_cycles", acc, dexp.acc);
         end
         t_done = cyc;
      end else begin
         chk("quiet", {req1_rdata, req0_rdata, req1_err, req0_err}, 0);
      end
      prev_psel = psel;
   end

   initial begin
      int i;
      repeat (3) @(negedge pclk);
      #1;
      chk("rst_ctl", {psel, penable, pwrite, busy}, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_req", {req0_ack, req1_ack, req0_done, req1_done,
                      req0_err, req1_err}, 0);
      chk("rst_rdata", {req1_rdata, req0_rdata}, 0);
      preset = 1'b0;
      repeat (2) @(negedge pclk);
      #1;

      // Zero-wait write from port 0 with cycle-exact timing.
      post(mk(1'b0, 1'b1, 32'h10, 16'hBEEF, 0, 16'h0, 1'b0), 1'b1);
      drain("t1");
      chk("t1_setup_lat", t_setup - tv0, 1);
      chk("t1_done_lat", t_done - tv0, 3);

      // Port 1 read with three wait states.
      post(mk(1'b1, 1'b0, 32'h24, 16'h0, 3, 16'h1234, 1'b0), 1'b1);
      drain("t2");

      // Both ports busy: strict alternation from reset.
      preset = 1'b1;
      @(negedge pclk); #1;
      preset = 1'b0;
      mark = 1'b1;
      post(mk(1'b0, 1'b1, 32'h100, 16'h1111, 0, 16'h0, 1'b0), 1'b1);
      post(mk(1'b1, 1'b0, 32'h200, 16'h0, 0, 16'h2222, 1'b0), 1'b1);
      post(mk(1'b0, 1'b0, 32'h104, 16'h0, 0, 16'h3333, 1'b0), 1'b1);
      post(mk(1'b1, 1'b1, 32'h204, 16'h4444, 0, 16'h0, 1'b0), 1'b1);
      drain("t3");
      chk("b2b_span", t_done - t_mark, 11);

      // Timeout: never ready, ready on 16th, ready one cycle too late.
      post(mk(1'b0, 1'b0, 32'h40, 16'h0, -1, 16'h7777, 1'b0), 1'b1);
      drain("t4a");
      post(mk(1'b0, 1'b0, 32'h44, 16'h0, 15, 16'h4321, 1'b0), 1'b1);
      drain("t4b");
      post(mk(1'b1, 1'b0, 32'h48, 16'h0, 16, 16'h9999, 1'b0), 1'b1);
      drain("t4c");

      // Slave error on a write, then a queued read on the same port.
      post(mk(1'b0, 1'b1, 32'h30, 16'hCAFE, 0, 16'h0, 1'b1), 1'b1);
      post(mk(1'b0, 1'b0, 32'h34, 16'h0, 1, 16'h5A5A, 1'b0), 1'b1);
      drain("t5");

      // Reset in the second ACCESS wait cycle of a port-0 read.
      post(mk(1'b0, 1'b0, 32'h80, 16'h0, 10, 16'hDEAD, 1'b0), 1'b0);
      i = 0;
      while (!(penable && acc == 2) && i < 50) begin
         @(negedge pclk); #1;
         i++;
      end
      chk("t6_reach_wait", acc, 2);
      preset = 1'b1;
      @(negedge pclk); #1;
      chk("t6_abort", {psel, penable, req0_done, req1_done, busy}, 0);
      preset = 1'b0;
      post(mk(1'b0, 1'b1, 32'h90, 16'h6060, 0, 16'h0, 1'b0), 1'b1);
      post(mk(1'b1, 1'b0, 32'h94, 16'h0, 0, 16'h7070, 1'b0), 1'b1);
      drain("t6");

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Two-requester APB master. Arbitrates round-robin between two local command ports and sequences the APB IDLE -> SETUP -> ACCESS protocol on one shared bus.
- Returns read data and error status to the winning requester. A programmable wait-state timeout stops the block hanging on a slave that never asserts pready.
- Sits between internal bus clients and the APB interface bundle. Its bus outputs must satisfy the interface's setup, access and wait-stability assertions.

Parameters:
- N, 16, data width of pwdata/prdata and request data.
- ADDR_WIDTH, 32, address width.
- TIMEOUT, 16, maximum ACCESS cycles with pready low before forced termination. 0 disables the timeout.

Ports:
- pclk  input  1  APB clock. All logic is on the rising edge.
- preset  input  1  Reset, synchronous and active-high.
- req0_valid  input  1  Requester 0 has a command.
- req0_write  input  1  1 = write, 0 = read.
- req0_addr  input  ADDR_WIDTH  Command address.
- req0_wdata  input  N  Write data.
- req0_ack  output  1  One-cycle pulse: command accepted and payload captured.
- req0_done  output  1  One-cycle pulse: transfer complete.
- req0_rdata  output  N  Read data, valid while req0_done is high.
- req0_err  output  1  pslverr or timeout, valid while req0_done is high.
- req1_*  same set as req0_*, for requester 1.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- paddr  output  ADDR_WIDTH  APB address.
- pwrite  output  1  APB direction.
- pwdata  output  N  APB write data.
- prdata  input  N  APB read data.
- pready  input  1  APB ready.
- pslverr  input  1  APB slave error.
- busy  output  1  High in SETUP and ACCESS.

Behaviour:
- Reset values: all outputs 0. State = IDLE. Timeout counter = 0. last_grant = 1, so requester 0 wins the first contention.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, SETUP, ACCESS.
- IDLE, one valid: if exactly one reqX_valid is high at the edge, grant X.
- IDLE, both valid: grant the requester that is not last_grant, then update last_grant.
- IDLE, on grant:
  - Capture addr/write/wdata into paddr/pwrite/pwdata.
  - Go to SETUP.
  - Next cycle: psel=1, penable=0, reqX_ack=1.
- SETUP: always goes to ACCESS after one cycle. Next cycle penable=1.
- ACCESS, pready=0: psel, penable, paddr, pwrite and pwdata hold stable. The wait counter increments.
- ACCESS, pready=1 at the edge:
  - Next cycle: psel=0, penable=0, state = IDLE.
  - reqX_done=1 for one cycle.
  - reqX_rdata = prdata for reads, 0 for writes.
  - reqX_err = pslverr.
- Timeout: if TIMEOUT != 0 and the counter reaches TIMEOUT with pready still low, the transfer terminates at that edge.
  - Termination is handled like completion, except reqX_err=1 and reqX_rdata=0.
  - A timeout and a pready on the same edge: pready wins.
- Requester handshake: reqX_valid and its payload are held until reqX_ack is seen. The requester may change them at the edge that ends the ack cycle. That edge is in SETUP, so no double accept is possible.
- The block never issues a second request for the same port until done.
- Minimum bus spacing: one IDLE cycle with psel=0 between transfers, which the done cycle provides. Back-to-back throughput is 3 cycles per zero-wait transfer.
- The IDLE cycle that carries reqX_done may also grant the next request, including from the same port.
- A non-granted requester's ack/done/rdata/err outputs stay 0.
- paddr/pwrite/pwdata retain their last value in IDLE. They are not required to return to 0.
- Reset asserted in any state:
  - At that edge, state goes to IDLE and all outputs go to reset values.
  - No done pulse is generated for an aborted transfer.
  - The counter clears and last_grant returns to 1.
- Timeout counter width is clog2(TIMEOUT+1), minimum 1. It clears on entry to ACCESS and must not wrap.

Test Plan:
- Req0 write, addr 0x10, data 0xBEEF, pready=1 in the first ACCESS.
  - SETUP at cycle 1 with req0_ack, ACCESS at cycle 2, req0_done at cycle 3 with err=0.
  - paddr=0x10 and pwdata=0xBEEF throughout; psel=0 at cycle 3.
- Req1 read, addr 0x24, pready low for 3 ACCESS cycles, prdata=0x1234.
  - psel, penable and paddr stable for all 4 ACCESS cycles.
  - req1_done then follows with rdata=0x1234.
- Both valid continuously, 4 transfers.
  - Grants alternate 0,1,0,1.
  - Each transfer is separated by exactly one psel=0 cycle.
  - Only the granted port pulses ack/done.
- TIMEOUT=16, pready never asserted.
  - After 16 ACCESS cycles, psel drops.
  - req0_done=1 with err=1 and rdata=0.
  - pready=1 on the 16th cycle instead gives a normal done with err=0.
- pslverr=1 with pready on a write: req0_done with err=1, and the next queued request proceeds normally.
- preset=1 during the second ACCESS wait cycle.
  - Next cycle: psel=penable=0 and no done.
  - After release with both valid, requester 0 is granted first.
